// File: rtl/ps2_lcd_line_buffer_pkg.sv
// Shared types and LCD constants for the PS2-to-LCD keystroke line buffer.
// Holds the controller state enum, the init instruction sequence and the per-row DDRAM bases.
package ps2_lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_INIT_WAIT,
    S_IDLE,
    S_ROM_WAIT,
    S_ISSUE_CHAR,
    S_WAIT_CHAR,
    S_ISSUE_LINE,
    S_WAIT_LINE
  } state_t;

  localparam logic [8:0] LCD_FUNC_SET   = 9'h038;
  localparam logic [8:0] LCD_DISP_ON    = 9'h00C;
  localparam logic [8:0] LCD_CLEAR      = 9'h001;
  localparam logic [8:0] LCD_ENTRY_MODE = 9'h006;
  localparam logic [8:0] LCD_HOME       = 9'h080;
  localparam int         INIT_LEN       = 5;

  localparam logic [6:0] ROW_BASE0 = 7'h00;
  localparam logic [6:0] ROW_BASE1 = 7'h40;
  localparam logic [6:0] ROW_BASE2 = 7'h14;
  localparam logic [6:0] ROW_BASE3 = 7'h54;

  function automatic logic [8:0] init_instr(input logic [2:0] idx);
    case (idx)
      3'd0:    return LCD_FUNC_SET;
      3'd1:    return LCD_DISP_ON;
      3'd2:    return LCD_CLEAR;
      3'd3:    return LCD_ENTRY_MODE;
      default: return LCD_HOME;
    endcase
  endfunction

  function automatic logic [6:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    return ROW_BASE0;
      2'd1:    return ROW_BASE1;
      2'd2:    return ROW_BASE2;
      default: return ROW_BASE3;
    endcase
  endfunction

  function automatic logic is_flush_state(input state_t s);
    return s inside {S_ROM_WAIT, S_ISSUE_CHAR, S_WAIT_CHAR, S_ISSUE_LINE, S_WAIT_LINE};
  endfunction

endpackage

// File: rtl/ps2_lcd_line_buffer_if.sv
// Bundle of PS2 input, ROM lookup, LCD command and status signals around the line buffer.
// The buffer sits on the slave side; the surrounding top level (or a bench) uses master.
interface ps2_lcd_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    PS2_code;
  logic          PS2_code_ready;
  logic          PS2_make_code;
  logic          Flush_I;
  logic [8:0]    ROM_address;
  logic [7:0]    ROM_q;
  logic          LCD_start;
  logic [8:0]    LCD_instruction;
  logic          LCD_done;
  logic          Init_done;
  logic [CW-1:0] Fill_level;
  logic          Overflow;
  logic          Busy;

  modport master (
    output PS2_code, PS2_code_ready, PS2_make_code, Flush_I, ROM_q, LCD_done,
    input  ROM_address, LCD_start, LCD_instruction, Init_done, Fill_level, Overflow, Busy
  );

  modport slave (
    input  PS2_code, PS2_code_ready, PS2_make_code, Flush_I, ROM_q, LCD_done,
    output ROM_address, LCD_start, LCD_instruction, Init_done, Fill_level, Overflow, Busy
  );

endinterface

// File: rtl/ps2_lcd_line_buffer_sync_fifo.sv
// Circular FIFO with push, pop and retract (drop newest); head is read combinationally.
// Push into a full FIFO and pop/retract on an empty one are ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             retract,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok, retract_ok;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign retract_ok = retract & ~empty & ~pop;
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)         wr_ptr <= wr_ptr + 1'b1;
      else if (retract_ok) wr_ptr <= wr_ptr - 1'b1;
      if (pop_ok)          rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok) - CW'(retract_ok);
    end
  end

endmodule

// File: rtl/ps2_lcd_line_buffer.sv
// Buffers PS2 make codes and flushes them to a multi-row LCD via the ROM translator.
// One cycle ROM wait plus one issue cycle per character; every LCD command waits for LCD_done.
module ps2_lcd_line_buffer
  import ps2_lcd_pkg::*;
#(
  parameter int         DEPTH           = 16,
  parameter int         FLUSH_THRESHOLD = 16,
  parameter int         COLS            = 16,
  parameter int         ROWS            = 2,
  parameter logic [7:0] ENTER_CODE      = 8'h5A,
  parameter logic [7:0] BKSP_CODE       = 8'h66
) (
  input logic     Clock_50,
  input logic     Resetn,
  ps2_lcd_if.slave bus
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t          state, state_next;
  logic            ready_d, init_done, overflow, lcd_start;
  logic [2:0]      init_idx;
  logic [8:0]      lcd_instr;
  logic [CW-1:0]   remaining, count, level_next;
  logic [COLW-1:0] col;
  logic [1:0]      row;
  logic [7:0]      head;
  logic            full, empty, busy, pop, done_ok, col_wrap;
  logic            key_edge, is_enter, is_bksp, is_data, push, retract, flush_req;

  assign key_edge = bus.PS2_code_ready & ~ready_d & bus.PS2_make_code & init_done;
  assign is_enter = key_edge & (bus.PS2_code == ENTER_CODE);
  assign is_bksp  = key_edge & (bus.PS2_code == BKSP_CODE);
  assign is_data  = key_edge & ~is_enter & ~is_bksp;
  assign busy     = is_flush_state(state);
  assign push     = is_data & ~full;
  assign retract  = is_bksp & ~busy & ~empty;
  assign done_ok  = bus.LCD_done & ~lcd_start;
  assign col_wrap = (col == COLW'(COLS - 1));

  // Occupancy after this cycle's key action; the flush snapshot includes a push that triggers it.
  assign level_next = count + CW'(push) - CW'(retract);
  assign flush_req  = is_enter | bus.Flush_I | (push & (level_next == CW'(FLUSH_THRESHOLD)));

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CW(CW)) u_fifo (
    .clk       (Clock_50),
    .rst_n     (Resetn),
    .push      (push),
    .push_data (bus.PS2_code),
    .pop       (pop),
    .retract   (retract),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      S_INIT:       state_next = S_INIT_WAIT;
      S_INIT_WAIT:  if (done_ok) state_next = (init_idx == 3'(INIT_LEN - 1)) ? S_IDLE : S_INIT;
      S_IDLE:       if (flush_req && level_next != '0) state_next = S_ROM_WAIT;
      S_ROM_WAIT:   state_next = S_ISSUE_CHAR;
      S_ISSUE_CHAR: state_next = S_WAIT_CHAR;
      S_WAIT_CHAR: begin
        if (done_ok) begin
          pop = 1'b1;
          if (col_wrap)                    state_next = S_ISSUE_LINE;
          else if (remaining != CW'(1))    state_next = S_ROM_WAIT;
          else                             state_next = S_IDLE;
        end
      end
      S_ISSUE_LINE: state_next = S_WAIT_LINE;
      S_WAIT_LINE:  if (done_ok) state_next = (remaining != '0) ? S_ROM_WAIT : S_IDLE;
      default:      state_next = S_INIT;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_INIT;
      ready_d   <= 1'b0;
      init_idx  <= '0;
      init_done <= 1'b0;
      remaining <= '0;
      col       <= '0;
      row       <= '0;
      overflow  <= 1'b0;
      lcd_start <= 1'b0;
      lcd_instr <= '0;
    end else begin
      state     <= state_next;
      ready_d   <= bus.PS2_code_ready;
      lcd_start <= 1'b0;
      case (state)
        S_INIT: begin
          lcd_start <= 1'b1;
          lcd_instr <= init_instr(init_idx);
        end
        S_INIT_WAIT: if (done_ok) begin
          init_idx <= init_idx + 3'd1;
          if (state_next == S_IDLE) init_done <= 1'b1;
        end
        S_IDLE: if (state_next == S_ROM_WAIT) remaining <= level_next;
        S_ISSUE_CHAR: begin
          lcd_start <= 1'b1;
          lcd_instr <= {1'b1, bus.ROM_q};
        end
        S_ISSUE_LINE: begin
          lcd_start <= 1'b1;
          lcd_instr <= {2'b01, row_base(row)};
        end
        default: ;
      endcase
      if (pop) begin
        remaining <= remaining - 1'b1;
        if (col_wrap) begin
          col <= '0;
          row <= (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (busy && state_next == S_IDLE) overflow <= 1'b0;
      if (is_data && full)              overflow <= 1'b1;
    end
  end

  assign bus.ROM_address     = (state == S_ROM_WAIT) ? {1'b0, head} : 9'd0;
  assign bus.LCD_start       = lcd_start;
  assign bus.LCD_instruction = lcd_instr;
  assign bus.Init_done       = init_done;
  assign bus.Fill_level      = count;
  assign bus.Overflow        = overflow;
  assign bus.Busy            = busy;

endmodule

// File: tb/tb_ps2_lcd_line_buffer.sv
// Scoreboard bench: stimulus queues hand-computed LCD commands, a monitor checks each LCD_start.
module tb_ps2_lcd_line_buffer;
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic lcd_hold = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] exp_q [$];

  ps2_lcd_if #(.DEPTH(4)) bus ();

  ps2_lcd_line_buffer #(
    .DEPTH(4), .FLUSH_THRESHOLD(4), .COLS(2), .ROWS(2),
    .ENTER_CODE(8'h5A), .BKSP_CODE(8'h66)
  ) dut (
    .Clock_50 (clk),
    .Resetn   (rst_n),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] rom(input logic [8:0] a);
    case (a)
      9'h01C:  return 8'h41;
      9'h032:  return 8'h42;
      default: return 8'h3F;
    endcase
  endfunction

  // Synchronous translation ROM: data valid one cycle after the address.
  always @(posedge clk) bus.ROM_q <= rom(bus.ROM_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // LCD responder: acknowledges each command a few cycles later unless held.
  initial begin
    bus.LCD_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.LCD_start) begin
        repeat (3) @(negedge clk);
        while (lcd_hold && rst_n) @(negedge clk);
        if (rst_n) begin
          bus.LCD_done = 1'b1;
          @(negedge clk);
          bus.LCD_done = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.LCD_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL lcd_unexpected: got %0h, expected no command", bus.LCD_instruction);
        end else begin
          e = exp_q.pop_front();
          chk("lcd_instr", bus.LCD_instruction, e);
        end
      end
    end
  end

  task automatic key(input logic [7:0] c, input logic mk);
    @(negedge clk);
    bus.PS2_code       = c;
    bus.PS2_make_code  = mk;
    bus.PS2_code_ready = 1'b1;
    @(negedge clk);
    bus.PS2_code_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.Flush_I = 1'b1;
    @(negedge clk);
    bus.Flush_I = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit need_idle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && (!need_idle || !bus.Busy)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h080);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(bus.LCD_start), 32'd0);
    chk({tag, "_instr"}, 32'(bus.LCD_instruction), 32'd0);
    chk({tag, "_rom"}, 32'(bus.ROM_address), 32'd0);
    chk({tag, "_init_done"}, 32'(bus.Init_done), 32'd0);
    chk({tag, "_fill"}, 32'(bus.Fill_level), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'd0);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.PS2_code       = 8'h00;
    bus.PS2_code_ready = 1'b0;
    bus.PS2_make_code  = 1'b0;
    bus.Flush_I        = 1'b0;

    @(negedge clk);
    chk_reset_outputs("reset");
    push_init();
    @(negedge clk);
    rst_n = 1'b1;

    // Key pressed during init must be discarded.
    key(8'h1C, 1'b1);
    chk("init_key_dropped", 32'(bus.Fill_level), 32'd0);
    wait_done("init_drain", 1'b0);
    repeat (8) @(negedge clk);
    chk("init_done", 32'(bus.Init_done), 32'd1);

    // Threshold flush across both rows and back to row 0.
    key(8'h1C, 1'b1); chk("thr_fill1", 32'(bus.Fill_level), 32'd1);
    key(8'h1C, 1'b1); chk("thr_fill2", 32'(bus.Fill_level), 32'd2);
    key(8'h1C, 1'b1); chk("thr_fill3", 32'(bus.Fill_level), 32'd3);
    exp_q.push_back(9'h141); exp_q.push_back(9'h141); exp_q.push_back(9'h0C0);
    exp_q.push_back(9'h141); exp_q.push_back(9'h141); exp_q.push_back(9'h080);
    key(8'h1C, 1'b1);
    chk("thr_busy", 32'(bus.Busy), 32'd1);
    chk("thr_fill4", 32'(bus.Fill_level), 32'd4);
    wait_done("thr_drain", 1'b1);
    chk("thr_fill_end", 32'(bus.Fill_level), 32'd0);

    // A, B, Enter from cursor row 0 col 0.
    key(8'h1C, 1'b1); chk("ab_fill1", 32'(bus.Fill_level), 32'd1);
    key(8'h32, 1'b1); chk("ab_fill2", 32'(bus.Fill_level), 32'd2);
    exp_q.push_back(9'h141); exp_q.push_back(9'h142); exp_q.push_back(9'h0C0);
    key(8'h5A, 1'b1);
    chk("ab_busy", 32'(bus.Busy), 32'd1);
    wait_done("ab_drain", 1'b1);
    chk("ab_fill_end", 32'(bus.Fill_level), 32'd0);

    // Backspace removes the newest entry.
    key(8'h1C, 1'b1); chk("bk_fill1", 32'(bus.Fill_level), 32'd1);
    key(8'h32, 1'b1); chk("bk_fill2", 32'(bus.Fill_level), 32'd2);
    key(8'h66, 1'b1); chk("bk_fill3", 32'(bus.Fill_level), 32'd1);
    exp_q.push_back(9'h141);
    key(8'h5A, 1'b1);
    wait_done("bk_drain", 1'b1);
    chk("bk_fill_end", 32'(bus.Fill_level), 32'd0);
    key(8'h66, 1'b1); chk("bk_empty", 32'(bus.Fill_level), 32'd0);
    key(8'h1C, 1'b0); chk("break_ignored", 32'(bus.Fill_level), 32'd0);

    // Manual flush of an empty buffer never raises Busy.
    pulse_flush();
    chk("empty_flush_busy0", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    chk("empty_flush_busy1", 32'(bus.Busy), 32'd0);

    // Keys during a stalled flush are stored, overflow when full, Enter ignored.
    key(8'h1C, 1'b1);
    lcd_hold = 1'b1;
    exp_q.push_back(9'h141); exp_q.push_back(9'h080);
    pulse_flush();
    chk("ovf_busy", 32'(bus.Busy), 32'd1);
    key(8'h32, 1'b1); chk("ovf_fill2", 32'(bus.Fill_level), 32'd2);
    key(8'h32, 1'b1); chk("ovf_fill3", 32'(bus.Fill_level), 32'd3);
    key(8'h32, 1'b1); chk("ovf_fill4", 32'(bus.Fill_level), 32'd4);
    chk("ovf_clear_before", 32'(bus.Overflow), 32'd0);
    key(8'h32, 1'b1);
    chk("ovf_set", 32'(bus.Overflow), 32'd1);
    chk("ovf_fill_full", 32'(bus.Fill_level), 32'd4);
    key(8'h5A, 1'b1);
    chk("ovf_enter_ignored", 32'(bus.Fill_level), 32'd4);
    lcd_hold = 1'b0;
    wait_done("ovf_drain", 1'b1);
    chk("ovf_cleared", 32'(bus.Overflow), 32'd0);
    chk("ovf_fill_left", 32'(bus.Fill_level), 32'd3);
    exp_q.push_back(9'h142); exp_q.push_back(9'h142);
    exp_q.push_back(9'h0C0); exp_q.push_back(9'h142);
    key(8'h5A, 1'b1);
    wait_done("rest_drain", 1'b1);
    chk("rest_fill_end", 32'(bus.Fill_level), 32'd0);

    // Reset in the middle of a flush, then init replays.
    key(8'h1C, 1'b1);
    lcd_hold = 1'b1;
    exp_q.push_back(9'h141);
    key(8'h5A, 1'b1);
    wait_done("mid_issue", 1'b0);
    chk("mid_busy", 32'(bus.Busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    lcd_hold = 1'b0;
    push_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("reinit_drain", 1'b0);
    repeat (8) @(negedge clk);
    chk("reinit_done", 32'(bus.Init_done), 32'd1);
    chk("reinit_fill", 32'(bus.Fill_level), 32'd0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
